// File: rtl/dense_sequencer.sv
// Sequencer for a bank of dense-layer MAC units: streams 8-value groups as 3 lanes x 3 phases, then emits per-unit sums.
// Latency: first mac_phase two cycles after start, mac_last at 3*NUM_GROUPS+1, first out_valid at 3*NUM_GROUPS+3.
// Backpressure: only the output stream stalls; out_data/out_index hold while out_valid & !out_ready.
//
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   start, base_addr     launch an inference (IDLE only), triplet address of group 0 phase 0
//   busy                 high while not IDLE
//   rd_en, rd_addr       RAM read strobe/address; rd_data returns one cycle later (3 lanes)
//   mac_clear            one-cycle accumulator clear in the first RUN cycle
//   mac_phase/group/data lane beat to the units, aligned with rd_data; mac_last flags the final beat
//   unit_sum             biased sums from the units
//   out_valid/ready/data/index  per-unit result stream; done pulses after the last transfer
module dense_sequencer #(
    parameter int NUM_GROUPS = 16,
    parameter int NUM_UNITS  = 16,
    parameter int ADDR_W     = 10,
    parameter int RELU       = 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic [ADDR_W-1:0]           base_addr,
    output logic                        busy,
    output logic                        rd_en,
    output logic [ADDR_W-1:0]           rd_addr,
    input  logic [2:0][15:0]            rd_data,
    output logic                        mac_clear,
    output logic [2:0]                  mac_phase,
    output logic [4:0]                  mac_group,
    output logic [2:0][15:0]            mac_data,
    output logic                        mac_last,
    input  logic [NUM_UNITS-1:0][15:0]  unit_sum,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic signed [15:0]          out_data,
    output logic [4:0]                  out_index,
    output logic                        done
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RUN    = 3'd1,
        DRAIN  = 3'd2,
        SETTLE = 3'd3,
        EMIT   = 3'd4
    } state_t;

    localparam logic [4:0] LAST_G = 5'(NUM_GROUPS - 1);
    localparam logic [4:0] LAST_U = 5'(NUM_UNITS - 1);

    state_t     state;
    logic [4:0] group;   // group of the read issued this cycle
    logic [1:0] phase;   // phase of the read issued this cycle

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            group     <= '0;
            phase     <= '0;
            busy      <= 1'b0;
            rd_en     <= 1'b0;
            rd_addr   <= '0;
            mac_clear <= 1'b0;
            mac_phase <= '0;
            mac_group <= '0;
            mac_last  <= 1'b0;
            out_valid <= 1'b0;
            out_index <= '0;
            done      <= 1'b0;
        end else begin
            // Beat tags follow the read by one cycle so they line up with rd_data.
            mac_phase <= rd_en ? (3'b001 << phase) : 3'b000;
            mac_group <= rd_en ? group : 5'd0;
            mac_last  <= rd_en && (phase == 2'd2) && (group == LAST_G);
            mac_clear <= 1'b0;
            done      <= 1'b0;

            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= RUN;
                        busy      <= 1'b1;
                        rd_en     <= 1'b1;
                        rd_addr   <= base_addr;
                        group     <= '0;
                        phase     <= '0;
                        mac_clear <= 1'b1;
                    end
                end
                RUN: begin
                    // base + group*3 + phase advances by exactly one per cycle,
                    // so a running increment gives the address and wraps naturally.
                    if (phase == 2'd2) begin
                        phase <= 2'd0;
                        if (group == LAST_G) begin
                            state <= DRAIN;
                            rd_en <= 1'b0;
                        end else begin
                            group   <= group + 5'd1;
                            rd_addr <= rd_addr + ADDR_W'(1);
                        end
                    end else begin
                        phase   <= phase + 2'd1;
                        rd_addr <= rd_addr + ADDR_W'(1);
                    end
                end
                DRAIN: begin
                    state <= SETTLE;
                end
                SETTLE: begin
                    // Units register their final accumulation during this cycle.
                    state     <= EMIT;
                    out_valid <= 1'b1;
                    out_index <= '0;
                end
                EMIT: begin
                    if (out_ready) begin
                        if (out_index == LAST_U) begin
                            state     <= IDLE;
                            busy      <= 1'b0;
                            out_valid <= 1'b0;
                            out_index <= '0;
                            done      <= 1'b1;
                        end else begin
                            out_index <= out_index + 5'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Lane 2 carries nothing on the third phase (8 = 3+3+2).
    always_comb begin
        mac_data = rd_data;
        if (mac_phase == 3'b000) begin
            mac_data = '0;
        end else if (mac_phase[2]) begin
            mac_data[2] = 16'd0;
        end
    end

    logic [15:0] sel_sum;

    always_comb begin
        sel_sum = 16'd0;
        for (int u = 0; u < NUM_UNITS; u++) begin
            if (out_index == 5'(u)) begin
                sel_sum = unit_sum[u];
            end
        end
        if (!out_valid) begin
            out_data = 16'sd0;
        end else if ((RELU != 0) && sel_sum[15]) begin
            out_data = 16'sd0;
        end else begin
            out_data = $signed(sel_sum);
        end
    end

endmodule

// File: tb/tb_dense_sequencer.sv
module tb_dense_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // DUT A: two groups, two units, ReLU on.  DUT B: one group, ReLU off.
    logic              reset = 1'b1;
    logic              out_ready = 1'b1;
    logic              start_a = 1'b0, start_b = 1'b0;
    logic [9:0]        base_a = '0, base_b = '0;
    logic              busy_a, rd_a, clr_a, last_a, ov_a, done_a;
    logic [9:0]        addr_a;
    logic [2:0][15:0]  rdat_a, mdat_a;
    logic [2:0]        ph_a;
    logic [4:0]        grp_a, oidx_a;
    logic [1:0][15:0]  usum_a = '0;
    logic signed [15:0] odat_a;
    logic              busy_b, rd_b, clr_b, last_b, ov_b, done_b;
    logic [9:0]        addr_b;
    logic [2:0][15:0]  rdat_b, mdat_b;
    logic [2:0]        ph_b;
    logic [4:0]        grp_b, oidx_b;
    logic [1:0][15:0]  usum_b = '0;
    logic signed [15:0] odat_b;

    dense_sequencer #(.NUM_GROUPS(2), .NUM_UNITS(2), .ADDR_W(10), .RELU(1)) dut_a (
        .clk(clk), .reset(reset), .start(start_a), .base_addr(base_a), .busy(busy_a),
        .rd_en(rd_a), .rd_addr(addr_a), .rd_data(rdat_a), .mac_clear(clr_a),
        .mac_phase(ph_a), .mac_group(grp_a), .mac_data(mdat_a), .mac_last(last_a),
        .unit_sum(usum_a), .out_valid(ov_a), .out_ready(out_ready), .out_data(odat_a),
        .out_index(oidx_a), .done(done_a));

    dense_sequencer #(.NUM_GROUPS(1), .NUM_UNITS(2), .ADDR_W(10), .RELU(0)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .base_addr(base_b), .busy(busy_b),
        .rd_en(rd_b), .rd_addr(addr_b), .rd_data(rdat_b), .mac_clear(clr_b),
        .mac_phase(ph_b), .mac_group(grp_b), .mac_data(mdat_b), .mac_last(last_b),
        .unit_sum(usum_b), .out_valid(ov_b), .out_ready(out_ready), .out_data(odat_b),
        .out_index(oidx_b), .done(done_b));

    // 1-cycle RAM: lanes of triplet a are {a, a+1, a+2}.
    always @(posedge clk) begin
        if (rd_a) rdat_a <= {16'(addr_a + 10'd2), 16'(addr_a + 10'd1), 16'(addr_a)};
        if (rd_b) rdat_b <= {16'(addr_b + 10'd2), 16'(addr_b + 10'd1), 16'(addr_b)};
    end

    int tests = 0, fails = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp_v);
        tests++;
        if (act !== exp_v) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
        end
    endtask

    typedef struct { int phase; int group; int l0; int l1; int l2; int last; } beat_t;
    typedef struct { int idx; int data; } obeat_t;
    typedef struct { int base; int us0; int us1; int exp0; int exp1; } tv_t;

    int     addr_qa[$], addr_qb[$];
    beat_t  beat_qa[$];
    obeat_t out_qa[$], out_qb[$];
    int     clr_cnt = 0;
    int     first_ph = -1, first_ov = -1, last_cyc = -1, done_cyc = -1;
    tv_t    tv[4];

    // Scoreboard model for DUT A: reads, lane beats and output stream.
    task automatic push_a(input int base, input int e0, input int e1);
        for (int k = 0; k < 6; k++) begin
            beat_t b;
            int a;
            a = (base + k) % 1024;
            addr_qa.push_back(a);
            b.phase = 1 << (k % 3);
            b.group = k / 3;
            b.l0 = a;
            b.l1 = a + 1;
            b.l2 = (k % 3 == 2) ? 0 : a + 2;
            b.last = (k == 5) ? 1 : 0;
            beat_qa.push_back(b);
        end
        out_qa.push_back('{0, e0});
        out_qa.push_back('{1, e1});
    endtask

    beat_t  mb;
    obeat_t mo;
    always @(negedge clk) begin
        if (rd_a) begin
            if (addr_qa.size() == 0) check("a_unexpected_read", 1, 0);
            else check("a_rd_addr", int'(addr_a), addr_qa.pop_front());
        end
        if (ph_a != 3'b000) begin
            if (first_ph < 0) first_ph = cyc;
            if (beat_qa.size() == 0) check("a_unexpected_beat", 1, 0);
            else begin
                mb = beat_qa.pop_front();
                check("a_mac_phase", int'(ph_a), mb.phase);
                check("a_mac_group", int'(grp_a), mb.group);
                check("a_lane0", int'(mdat_a[0]), mb.l0);
                check("a_lane1", int'(mdat_a[1]), mb.l1);
                check("a_lane2", int'(mdat_a[2]), mb.l2);
                check("a_mac_last", int'(last_a), mb.last);
            end
        end else if (last_a) begin
            check("a_stray_last", 1, 0);
        end
        if (last_a) last_cyc = cyc;
        if (clr_a) clr_cnt++;
        if (ov_a && first_ov < 0) first_ov = cyc;
        if (ov_a && out_ready) begin
            if (out_qa.size() == 0) check("a_unexpected_out", 1, 0);
            else begin
                mo = out_qa.pop_front();
                check("a_out_index", int'(oidx_a), mo.idx);
                check("a_out_data", int'(odat_a), mo.data);
            end
        end
        if (rd_b) begin
            if (addr_qb.size() == 0) check("b_unexpected_read", 1, 0);
            else check("b_rd_addr", int'(addr_b), addr_qb.pop_front());
        end
        if (ov_b && out_ready) begin
            if (out_qb.size() == 0) check("b_unexpected_out", 1, 0);
            else begin
                mo = out_qb.pop_front();
                check("b_out_index", int'(oidx_b), mo.idx);
                check("b_out_data", int'(odat_b), mo.data);
            end
        end
    end

    // Returns at the negedge of the cycle where done_a is high.
    task automatic wait_done_a();
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (done_a) begin
                done_cyc = cyc;
                return;
            end
        end
        check("a_done_timeout", 0, 1);
    endtask

    task automatic wait_valid_a();
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (ov_a) return;
        end
        check("a_valid_timeout", 0, 1);
    endtask

    task automatic check_empty(input string tag);
        check({tag, "_addr_q_left"}, addr_qa.size(), 0);
        check({tag, "_beat_q_left"}, beat_qa.size(), 0);
        check({tag, "_out_q_left"}, out_qa.size(), 0);
    endtask

    task automatic pulse_start_a(input int base, input bit now);
        if (!now) begin
            @(posedge clk);
            #1;
        end
        start_a = 1'b1;
        base_a = 10'(base);
    endtask

    // One full inference on DUT A with latency checks; b2b starts in the done cycle.
    task automatic run_vec(input int i, input bit b2b);
        int st, clr0;
        usum_a = {16'(tv[i].us1), 16'(tv[i].us0)};
        push_a(tv[i].base, tv[i].exp0, tv[i].exp1);
        first_ph = -1; first_ov = -1; last_cyc = -1; done_cyc = -1;
        clr0 = clr_cnt;
        pulse_start_a(tv[i].base, b2b);
        st = cyc;
        @(posedge clk);
        #1 start_a = 1'b0;
        wait_done_a();
        check("first_phase_cycle", first_ph, st + 2);
        check("mac_last_cycle", last_cyc, st + 7);
        check("first_valid_cycle", first_ov, st + 9);
        check("done_cycle", done_cyc, st + 11);
        check("busy_in_done_cycle", int'(busy_a), 0);
        check("clear_count", clr_cnt - clr0, 1);
        check_empty("vec");
    endtask

    initial begin
        int clr0;
        tv[0] = '{0,    -5,    300,    0,     300};
        tv[1] = '{1022, 7,     -32768, 7,     0};
        tv[2] = '{100,  32767, -1,     32767, 0};
        tv[3] = '{5,    0,     1,      0,     1};

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_busy", int'(busy_a), 0);
        check("rst_rd_en", int'(rd_a), 0);
        check("rst_mac_phase", int'(ph_a), 0);
        check("rst_out_valid", int'(ov_a), 0);
        check("rst_done", int'(done_a), 0);
        check("rst_mac_clear", int'(clr_a), 0);
        check("rst_busy_b", int'(busy_b), 0);

        for (int i = 0; i < 4; i++) run_vec(i, 1'b0);

        // start in the same cycle as done is honoured
        run_vec(0, 1'b1);
        run_vec(1, 1'b1);

        // backpressure: hold idx 1 for four cycles
        usum_a = {16'sd300, -16'sd5};
        push_a(0, 0, 300);
        out_ready = 1'b0;
        pulse_start_a(0, 1'b0);
        @(posedge clk);
        #1 start_a = 1'b0;
        wait_valid_a();
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("stall_valid", int'(ov_a), 1);
            check("stall_index", int'(oidx_a), 1);
            check("stall_data", int'(odat_a), 300);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        wait_done_a();
        check_empty("stall");

        // starts during RUN and EMIT are ignored
        usum_a = {16'sd9, 16'sd4};
        push_a(3, 4, 9);
        clr0 = clr_cnt;
        out_ready = 1'b0;
        pulse_start_a(3, 1'b0);
        @(posedge clk);
        #1 start_a = 1'b0;
        repeat (2) @(posedge clk);
        #1 start_a = 1'b1; base_a = 10'd500;
        @(posedge clk);
        #1 start_a = 1'b0;
        wait_valid_a();
        @(posedge clk);
        #1 start_a = 1'b1;
        @(posedge clk);
        #1 start_a = 1'b0; out_ready = 1'b1;
        wait_done_a();
        repeat (3) @(negedge clk);
        check("ignored_start_clears", clr_cnt - clr0, 1);
        check("ignored_start_busy", int'(busy_a), 0);
        check("ignored_start_rd_en", int'(rd_a), 0);
        check_empty("ignore");

        // reset in the fourth RUN cycle
        push_a(0, 0, 300);
        usum_a = {16'sd300, -16'sd5};
        pulse_start_a(0, 1'b0);
        @(posedge clk);
        #1 start_a = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("midrst_rd_en", int'(rd_a), 0);
        check("midrst_mac_phase", int'(ph_a), 0);
        check("midrst_busy", int'(busy_a), 0);
        check("midrst_out_valid", int'(ov_a), 0);
        addr_qa.delete();
        beat_qa.delete();
        out_qa.delete();
        run_vec(0, 1'b0);

        // DUT B: ReLU off, one group, address wrap at 1022
        usum_b = {16'sd300, -16'sd5};
        addr_qb.push_back(1022);
        addr_qb.push_back(1023);
        addr_qb.push_back(0);
        out_qb.push_back('{0, -5});
        out_qb.push_back('{1, 300});
        @(posedge clk);
        #1 start_b = 1'b1; base_b = 10'd1022;
        @(posedge clk);
        #1 start_b = 1'b0;
        begin
            bit seen;
            seen = 1'b0;
            for (int i = 0; i < 100 && !seen; i++) begin
                @(negedge clk);
                if (done_b) seen = 1'b1;
            end
            check("b_done_seen", int'(seen), 1);
        end
        check("b_addr_q_left", addr_qb.size(), 0);
        check("b_out_q_left", out_qb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
